// File: rtl/screen_state_ctrl.sv
// screen_state_ctrl: game-flow FSM producing the screen-select code, per-tank lives and the playfield clear pulse.
// Optional draw screen (player_screen = 11) is enabled by defining SCREEN_DRAW_EN.
module screen_state_ctrl #(
  parameter int LIVES      = 3,
  parameter int LIFE_W     = 2,
  parameter int WIN_FRAMES = 180,
  parameter int TMR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start_sw,
  input  logic              hit1,
  input  logic              hit2,
  output logic [1:0]        player_screen,
  output logic              reset_screen,
  output logic [LIFE_W-1:0] lives1,
  output logic [LIFE_W-1:0] lives2,
  output logic              game_active
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_WIN1  = 3'd2;
  localparam logic [2:0] S_WIN2  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
`ifdef SCREEN_DRAW_EN
  localparam logic [2:0] S_DRAW  = 3'd5;
`endif

  localparam logic [LIFE_W-1:0] LIVES_V  = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0] LIFE_ONE = LIFE_W'(1);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WIN_FRAMES - 1);

  logic [2:0]        state;
  logic [2:0]        state_n;
  logic [LIFE_W-1:0] lives1_n;
  logic [LIFE_W-1:0] lives2_n;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_n;
  logic [1:0]        screen_n;
  logic              start_sw_q;
  logic              start_rise;
  logic              final1;
  logic              final2;

  assign start_rise = start_sw & ~start_sw_q;
  assign final1     = hit1 && (lives1 == LIFE_ONE);
  assign final2     = hit2 && (lives2 == LIFE_ONE);

  always_comb begin
    state_n  = state;
    lives1_n = lives1;
    lives2_n = lives2;
    timer_n  = timer;
    case (state)
      S_IDLE: begin
        lives1_n = LIVES_V;
        lives2_n = LIVES_V;
        timer_n  = '0;
        if (start_rise)
          state_n = S_PLAY;
      end
      S_PLAY: begin
        timer_n = '0;
        // Dropping the play switch aborts the game and wins over any hit in the same cycle.
        if (!start_sw) begin
          state_n  = S_IDLE;
          lives1_n = LIVES_V;
          lives2_n = LIVES_V;
        end else begin
          if (hit1 && (lives1 != '0))
            lives1_n = lives1 - LIFE_ONE;
          if (hit2 && (lives2 != '0))
            lives2_n = lives2 - LIFE_ONE;
          if (final1 && final2) begin
`ifdef SCREEN_DRAW_EN
            state_n = S_DRAW;
`else
            state_n = S_WIN1;
`endif
          end else if (final2) begin
            state_n = S_WIN1;
          end else if (final1) begin
            state_n = S_WIN2;
          end
        end
      end
      S_WIN1, S_WIN2
`ifdef SCREEN_DRAW_EN
      , S_DRAW
`endif
      : begin
        if (frame_tick) begin
          if (timer == TMR_LAST) begin
            state_n  = S_CLEAR;
            timer_n  = '0;
            lives1_n = LIVES_V;
            lives2_n = LIVES_V;
          end else begin
            timer_n = timer + TMR_ONE;
          end
        end
      end
      S_CLEAR: begin
        state_n  = S_IDLE;
        lives1_n = LIVES_V;
        lives2_n = LIVES_V;
        timer_n  = '0;
      end
      default: begin
        state_n  = S_IDLE;
        lives1_n = LIVES_V;
        lives2_n = LIVES_V;
        timer_n  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    screen_n = 2'b00;
    case (state_n)
      S_WIN1:  screen_n = 2'b01;
      S_WIN2:  screen_n = 2'b10;
`ifdef SCREEN_DRAW_EN
      S_DRAW:  screen_n = 2'b11;
`endif
      default: screen_n = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      player_screen <= 2'b00;
      reset_screen  <= 1'b0;
      lives1        <= LIVES_V;
      lives2        <= LIVES_V;
      game_active   <= 1'b0;
      timer         <= '0;
      start_sw_q    <= 1'b1;
    end else begin
      state         <= state_n;
      player_screen <= screen_n;
      reset_screen  <= (state_n == S_CLEAR);
      lives1        <= lives1_n;
      lives2        <= lives2_n;
      game_active   <= (state_n == S_PLAY);
      timer         <= timer_n;
      start_sw_q    <= start_sw;
    end
  end

endmodule

// File: doc/screen_state_ctrl.md
Name: screen_state_ctrl

Overview:
- Game-flow controller that generates the screen-select code consumed by the display colour mux: 00 for title or play, 01 for a player-1 win, 10 for a player-2 win.
- Tracks per-tank lives from hit pulses and detects game end.
- Holds the win screen for a fixed number of frames, then pulses reset_screen to clear the playfield and returns to the title screen.
- Sits between the tank/shell collision logic (upstream) and the pixel output mux (downstream).

Parameters:
- LIVES, 3: lives loaded per tank at game start; must be ≥1 and ≤ 2^LIFE_W-1.
- LIFE_W, 2: width of the lives counters.
- WIN_FRAMES, 180: frame_tick count the win screen is held (3 s at 60 Hz); must be ≥1.
- TMR_W, 8: width of the win-hold timer; must satisfy 2^TMR_W > WIN_FRAMES.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_sw  in  1  play switch (board SW[1]); level signal
- hit1  in  1  one-cycle pulse: tank 1 struck
- hit2  in  1  one-cycle pulse: tank 2 struck
- player_screen  out  2  00 none, 01 player 1 wins, 10 player 2 wins, 11 draw (optional feature only)
- reset_screen  out  1  one-cycle pulse: clear playfield/tank positions
- lives1  out  LIFE_W  tank 1 remaining lives
- lives2  out  LIFE_W  tank 2 remaining lives
- game_active  out  1  high only in PLAY

Behaviour:
- One clock, clk. reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, player_screen 00, reset_screen 0, lives1 = lives2 = LIVES, game_active 0, timer 0, start_sw history register = 1.
  - Forcing history to 1 means a switch that is already high at reset does not start a game.
- start_rise = start_sw & ~start_sw_q, where start_sw_q is start_sw registered one cycle.
- IDLE:
  - Outputs: player_screen 00; lives held at LIVES.
  - Goes to PLAY on start_rise. game_active rises the cycle after start_rise.
- PLAY:
  - hit1 decrements lives1 and hit2 decrements lives2, both saturating at 0.
  - Simultaneous hit1 and hit2 both apply in the same cycle.
  - If start_sw == 0, go to IDLE and reload lives. This abort has priority over hits that cycle. reset_screen is not pulsed.
  - Final-hit rules (final means the decrement takes lives from 1 to 0):
    - Final hit2 only: go to WIN1; player_screen = 01 from the next cycle.
    - Final hit1 only: go to WIN2; player_screen = 10.
    - Both final in the same cycle, macro absent: go to WIN1 (player 1 has priority). Both lives display 0.
  - Latency: hit pulse to player_screen change is 1 cycle.
- WIN1 / WIN2:
  - player_screen held; hit1, hit2 and start_sw are ignored; game_active 0.
  - Timer clears on entry and increments on each frame_tick.
  - When a frame_tick arrives with timer == WIN_FRAMES-1, go to CLEAR.
  - The win screen therefore lasts exactly WIN_FRAMES ticks.
- CLEAR:
  - Lasts one cycle: reset_screen = 1, player_screen = 00, lives reloaded to LIVES, timer cleared.
  - Next state is IDLE.
  - A new game requires a fresh 0→1 edge of start_sw, even if the switch stayed high throughout.
- reset asserted in any state, including mid-win: return to reset values next cycle. No reset_screen pulse is generated.
- Undefined state encodings recover to IDLE.

Optional Feature:
- Macro: SCREEN_DRAW_EN.
- Defined:
  - Adds a DRAW state, entered when both final hits land in the same PLAY cycle.
  - DRAW outputs player_screen = 11 and uses the same WIN_FRAMES hold, CLEAR and reset_screen sequence.
  - The downstream mux treats 11 as its default path.
- Undefined:
  - No DRAW state; player_screen never equals 11.
  - Simultaneous final hits go to WIN1.

Test Plan:
- reset with start_sw=1 held → stays IDLE, player_screen 00, game_active 0. Drop start_sw to 0 then raise it to 1 → game_active 1 one cycle after the rise; lives1 = lives2 = 3.
- In PLAY, 3 hit2 pulses on separate cycles → lives2 goes 2,1,0; on the cycle after the third pulse, player_screen 01 and game_active 0. Subsequent hit1 pulses leave lives1 at 3.
- WIN1 with WIN_FRAMES=4 → player_screen stays 01 through 4 frame_ticks. reset_screen is high for exactly 1 cycle after the 4th tick, then player_screen 00 and lives reload to 3. IDLE does not restart while start_sw stays high.
- In PLAY with lives1 = lives2 = 1, hit1 and hit2 in the same cycle → macro absent: player_screen 01; SCREEN_DRAW_EN defined: player_screen 11, followed by the same hold/clear sequence.
- In PLAY, hit1 twice (lives1=1), then start_sw=0 in the same cycle as a hit1 → IDLE, lives1 = lives2 = 3, no reset_screen pulse, player_screen stays 00.
- In WIN2 at timer=2, assert reset for 1 cycle → player_screen 00, lives 3/3, no reset_screen pulse, state IDLE.
